debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  NCH-channel button/switch debouncer with press and release ticks, long-press detect and auto-repeat.
//  Each channel has its own 2-flop synchronizer, 4-state FSM and counters. All channels run
//  independently on one clock. Sits between the board push-buttons/switches and the menu/control FSMs.
// PARAMETERS
//  NCH            5          number of independent channels
//  DB_CYCLES      4_000_000  stable cycles required to accept an edge (40 ms @100 MHz); >=2
//  LONG_CYCLES    100_000_000 held cycles after rise_tick before long_tick (1 s); >=1
//  REPEAT_CYCLES  20_000_000 repeat period after long_tick (200 ms); 0 disables repeat
// PORTS
//  clk          in   1    system clock (100 MHz)
//  reset        in   1    asynchronous, active-high reset
//  btn          in   NCH  raw asynchronous inputs, 1 = pressed
//  db_level     out  NCH  debounced level, registered
//  rise_tick    out  NCH  1-cycle pulse, accepted press
//  fall_tick    out  NCH  1-cycle pulse, accepted release
//  long_tick    out  NCH  1-cycle pulse, press held LONG_CYCLES
//  repeat_tick  out  NCH  1-cycle pulse, every REPEAT_CYCLES after long_tick while held
// BEHAVIOUR
//  - Reset (async): sync flops, FSM = ZERO, counters, and all outputs = 0. A button held through
//    reset release is debounced fresh and produces a normal rise_tick.
//  - Sync: btn -> s1 -> s2. FSM sees only s2.
//  - Debounce counter dcnt, width $clog2(DB_CYCLES). Loaded with DB_CYCLES-1. Decrements by 1 per cycle.
//  - States per channel:
//    - ZERO: s2=1 -> load dcnt, go WAIT1.
//    - WAIT1: s2=0 -> ZERO with no tick. dcnt!=0 -> decrement. dcnt==0 -> ONE.
//    - ONE: s2=0 -> load dcnt, go WAIT0.
//    - WAIT0: s2=1 -> ONE with no tick. dcnt!=0 -> decrement. dcnt==0 -> ZERO.
//  - Outputs are registered. db_level=1 in ONE/WAIT0, 0 in ZERO/WAIT1.
//    - rise_tick: high only in the first cycle db_level=1.
//    - fall_tick: high only in the first cycle db_level=0.
//  - Latency: if s1 captures 1 at edge k and btn stays high, db_level/rise_tick go high after edge
//    k+DB_CYCLES+2. Release latency is identical.
//  - Any bounce shorter than DB_CYCLES consecutive stable samples produces no output change.
//  - Hold counter hcnt (width fits LONG_CYCLES+REPEAT_CYCLES):
//    - Clears on ZERO->...->ONE entry (at rise_tick).
//    - Increments each cycle in ONE. Frozen in WAIT0. Cleared when ZERO is entered.
//  - long_tick: pulses once when hcnt reaches LONG_CYCLES, i.e. LONG_CYCLES cycles after the rise_tick cycle
//    with no WAIT0 excursions.
//  - repeat_tick (REPEAT_CYCLES>0): hcnt wraps to LONG_CYCLES-? not used. A separate rcnt reloads each
//    REPEAT_CYCLES. Pulses at LONG_CYCLES+n*REPEAT_CYCLES (n>=1) held cycles. Never pulses with long_tick.
//  - REPEAT_CYCLES=0: no repeat_tick ever. hcnt saturates at LONG_CYCLES and does not wrap.
//  - rise_tick, long_tick and fall_tick are mutually exclusive per channel per cycle.
//  - Different channels may tick in the same cycle.
//  - Reset mid-debounce or mid-hold aborts immediately. No pending tick is emitted.
// TESTING (bench params: NCH=2, DB_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3)
//  1. Clean press: btn[0]=1 sampled at edge 0, held.
//     -> db_level[0]=1 and rise_tick[0]=1 after edge 6, for 1 cycle. Channel 1 unchanged.
//  2. Bounce: btn[0] toggles 1,1,0,1,1,1,0 then 0.
//     -> no rise_tick, db_level stays 0. A later stable 4+ cycle press gives one rise_tick.
//  3. Long/repeat: hold btn[0].
//     -> long_tick 10 cycles after rise_tick; repeat_tick at +13, +16, +19.
//     Release -> fall_tick DB_CYCLES+2 cycles after release, no further repeat.
//  4. Release glitch: while held in ONE, drop btn 2 cycles.
//     -> no fall_tick, db_level stays 1, long_tick delayed by the frozen WAIT0 cycles.
//  5. Simultaneous: both channels pressed same edge.
//     -> rise_tick=2'b11 same cycle. Release ch1 only -> fall_tick=2'b10.
//  6. Reset mid-operation: assert reset during WAIT1 and during ONE.
//     -> all outputs 0 immediately. Button held across reset release -> rise_tick DB_CYCLES+2 cycles later.

Source files
------------

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//   Multi-channel push-button / switch debouncer. Each channel has its own
//   two-flop synchronizer and a four-state debounce FSM (ZERO, WAIT1, ONE,
//   WAIT0) with a debounce counter. Every channel reports an accepted press
//   (rise_tick), an accepted release (fall_tick), a long press (long_tick) and
//   an auto-repeat while still held (repeat_tick). Channels are independent
//   and share one clock.
//
// Ports
//   clk          in   1    system clock
//   reset        in   1    asynchronous, active-high reset
//   btn          in   NCH  raw asynchronous inputs, 1 = pressed
//   db_level     out  NCH  debounced level, registered
//   rise_tick    out  NCH  one-cycle pulse on accepted press
//   fall_tick    out  NCH  one-cycle pulse on accepted release
//   long_tick    out  NCH  one-cycle pulse once the press has been held
//                          LONG_CYCLES cycles after rise_tick
//   repeat_tick  out  NCH  one-cycle pulse every REPEAT_CYCLES after
//                          long_tick while held (REPEAT_CYCLES = 0 disables)
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int NCH           = 5,
  parameter int DB_CYCLES     = 4_000_000,
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] btn,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] rise_tick,
  output logic [NCH-1:0] fall_tick,
  output logic [NCH-1:0] long_tick,
  output logic [NCH-1:0] repeat_tick
);

  localparam int DW = $clog2(DB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + REPEAT_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LOAD   = DW'(DB_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE     = DW'(1'b1);
  localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_ONE     = HW'(1'b1);
  localparam logic [RW-1:0] R_ONE     = RW'(1'b1);
  // Last value of the repeat counter before it reloads; unused when repeat is off.
  localparam logic [RW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? RW'(REPEAT_CYCLES - 1) : {RW{1'b0}};

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } state_t;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic          sync1_r, sync2_r;
    state_t        state_r, state_s;
    logic [DW-1:0] dcnt_r, dcnt_s;
    logic [HW-1:0] hcnt_r, hcnt_s;
    logic [RW-1:0] rcnt_r, rcnt_s;
    logic          level_s, rise_s, fall_s, long_s, rep_s;
    logic          level_r, rise_r, fall_r, long_r, rep_r;

    // Two-flop synchronizer for the raw button input.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
      end else begin
        sync1_r <= btn[ch];
        sync2_r <= sync1_r;
      end
    end

    // State register together with the debounce, hold and repeat counters.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_r <= ST_ZERO;
        dcnt_r  <= {DW{1'b0}};
        hcnt_r  <= {HW{1'b0}};
        rcnt_r  <= {RW{1'b0}};
      end else begin
        state_r <= state_s;
        dcnt_r  <= dcnt_s;
        hcnt_r  <= hcnt_s;
        rcnt_r  <= rcnt_s;
      end
    end

    // Next-state logic: an edge is accepted only after DB_CYCLES stable samples.
    always_comb begin
      state_s = state_r;
      dcnt_s  = dcnt_r;
      case (state_r)
        ST_ZERO: begin
          if (sync2_r) begin
            state_s = ST_WAIT1;
            dcnt_s  = DB_LOAD;
          end else begin
            state_s = ST_ZERO;
          end
        end
        ST_WAIT1: begin
          if (!sync2_r) begin
            state_s = ST_ZERO;
          end else if (dcnt_r != {DW{1'b0}}) begin
            dcnt_s = dcnt_r - D_ONE;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_ONE: begin
          if (!sync2_r) begin
            state_s = ST_WAIT0;
            dcnt_s  = DB_LOAD;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_WAIT0: begin
          if (sync2_r) begin
            state_s = ST_ONE;
          end else if (dcnt_r != {DW{1'b0}}) begin
            dcnt_s = dcnt_r - D_ONE;
          end else begin
            state_s = ST_ZERO;
          end
        end
        default: begin
          state_s = ST_ZERO;
          dcnt_s  = {DW{1'b0}};
        end
      endcase
    end

    // Hold / repeat counting. hcnt saturates at LONG_CYCLES; from then on the
    // separate rcnt paces the repeat pulses. Both stay frozen in WAIT0 so a
    // short release glitch only delays long_tick instead of restarting it.
    always_comb begin
      hcnt_s = hcnt_r;
      rcnt_s = rcnt_r;
      long_s = 1'b0;
      rep_s  = 1'b0;
      if (state_s == ST_ZERO) begin
        hcnt_s = {HW{1'b0}};
        rcnt_s = {RW{1'b0}};
      end else if ((state_r == ST_WAIT1) && (state_s == ST_ONE)) begin
        hcnt_s = {HW{1'b0}};
        rcnt_s = {RW{1'b0}};
      end else if (state_r == ST_ONE) begin
        if (hcnt_r < HOLD_LONG) begin
          hcnt_s = hcnt_r + H_ONE;
          long_s = ((hcnt_r + H_ONE) == HOLD_LONG);
        end else if (REPEAT_CYCLES > 0) begin
          if (rcnt_r == REP_LAST) begin
            rcnt_s = {RW{1'b0}};
            rep_s  = 1'b1;
          end else begin
            rcnt_s = rcnt_r + R_ONE;
          end
        end else begin
          hcnt_s = hcnt_r;
        end
      end else begin
        hcnt_s = hcnt_r;
      end
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
      level_s = (state_s == ST_ONE) || (state_s == ST_WAIT0);
      rise_s  = (state_r == ST_WAIT1) && (state_s == ST_ONE);
      fall_s  = (state_r == ST_WAIT0) && (state_s == ST_ZERO);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        level_r <= 1'b0;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
        long_r  <= 1'b0;
        rep_r   <= 1'b0;
      end else begin
        level_r <= level_s;
        rise_r  <= rise_s;
        fall_r  <= fall_s;
        long_r  <= long_s;
        rep_r   <= rep_s;
      end
    end

    assign db_level[ch]    = level_r;
    assign rise_tick[ch]   = rise_r;
    assign fall_tick[ch]   = fall_r;
    assign long_tick[ch]   = long_r;
    assign repeat_tick[ch] = rep_r;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi with NCH=2, DB_CYCLES=4, LONG_CYCLES=10,
// REPEAT_CYCLES=3. Each table row holds btn for n cycles; btn changes on the
// falling edge and outputs are compared 1 time unit after each rising edge.
module tb_debounce_multi;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn   = 2'b00;
  logic [1:0] db_level, rise_tick, fall_tick, long_tick, repeat_tick;
  logic [9:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int         n;
    logic [1:0] btn;
    logic [9:0] exp;   // {level, rise, fall, long, repeat}
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  debounce_multi #(
    .NCH(2), .DB_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn),
    .db_level(db_level), .rise_tick(rise_tick), .fall_tick(fall_tick),
    .long_tick(long_tick), .repeat_tick(repeat_tick)
  );

  assign obs = {db_level, rise_tick, fall_tick, long_tick, repeat_tick};

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [1:0] b, input logic [1:0] lvl,
                              input logic [1:0] ri, input logic [1:0] fa,
                              input logic [1:0] lo, input logic [1:0] re);
    vec_t v;
    v.n   = n;
    v.btn = b;
    v.exp = {lvl, ri, fa, lo, re};
    return v;
  endfunction

  // Waits (bounded) for rise_tick[0]; returns the 0-based edge index or -1.
  task automatic find_rise(output int seen);
    seen = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (rise_tick[0] === 1'b1) begin
        seen = c;
        break;
      end
    end
  endtask

  initial begin
    int row;
    int seen;
    // Clean press, long press, three repeats, release.
    vecs.push_back(mk(6, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(9, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(2, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(2, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(4, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // Bounce: 1,1,0,1,1,1,0 then 0 -> nothing.
    vecs.push_back(mk(2, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // Stable press after the bounce.
    vecs.push_back(mk(6, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    // Release glitch of 2 cycles: long_tick moves from +10 to +12.
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(8, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk(4, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    // Simultaneous press, release ch1 only, then ch0.
    vecs.push_back(mk(6, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(6, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(5, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 0, 32'(obs), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    row = 0;
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        @(negedge clk);
        btn = vecs[i].btn;
        @(posedge clk);
        #1;
        check("vec", row, 32'(obs), 32'(vecs[i].exp));
        row++;
      end
    end

    // Reset during WAIT1, button held across release.
    @(negedge clk);
    btn = 2'b01;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_wait1_outs", 0, 32'(obs), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    find_rise(seen);
    check("rst_wait1_rise_edge", 0, 32'(seen), 32'd6);
    check("rst_wait1_level", 0, 32'(db_level), 32'h1);

    // Reset during ONE: outputs drop at once, fresh debounce afterwards.
    repeat (3) @(posedge clk);
    #1;
    check("one_level_before", 0, 32'(db_level), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_one_outs", 0, 32'(obs), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    find_rise(seen);
    check("rst_one_rise_edge", 0, 32'(seen), 32'd6);

    @(negedge clk);
    btn = 2'b00;
    repeat (12) @(posedge clk);
    #1;
    check("final_idle", 0, 32'(obs), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
